data_route_arb: RTL and testbench
=================================

DATA_ROUTE_ARB -- requirements
Module: data_route_arb

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4 (legal 2..16), giving the number of merged column-FIFO channels.
REQ-002 The block SHALL have parameter DATA_W, default 28, giving the width of each channel's data word.
REQ-003 The block SHALL derive CH_W = max(1, clog2(NUM_CH)) and OUT_W (see REQ-019).
REQ-004 clk_40MHz  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 route_data_in  input  NUM_CH*DATA_W  channel i word at bits [i*DATA_W +: DATA_W]; first-word-fall-through, valid while empty_merge[i]=0.
REQ-007 empty_merge  input  NUM_CH  1 = channel i FIFO empty.
REQ-008 shake_hands_merge  output  NUM_CH  one-hot-or-zero pop strobe to channel FIFOs, one word per high cycle.
REQ-009 shakehands_proc  input  1  downstream ready.
REQ-010 route_data_proc  output  OUT_W  merged word, registered.
REQ-011 route_valid_proc  output  1  route_data_proc holds a word.

Function
REQ-012 The block SHALL contain one output register, with a 2-state FSM: IDLE (register empty) and FULL (register holds a word).
REQ-013 The block SHALL compute load = (state==IDLE) | (shakehands_proc & route_valid_proc), combinationally.
REQ-014 When load=1, the block SHALL search channels starting at (ptr+1) mod NUM_CH, ascending with wrap, and select the first i with empty_merge[i]=0.
REQ-015 When load=1 and a channel i is found, the block SHALL assert shake_hands_merge[i] in that cycle, capture route_data_in channel i into the register at the next edge, set ptr=i, and enter or stay in FULL.
REQ-016 When load=1 and all channels are empty, the block SHALL drive shake_hands_merge=0, go to IDLE (route_valid_proc=0 next cycle) and leave ptr unchanged.
REQ-017 When FULL and shakehands_proc=0, the block SHALL hold route_data_proc stable and drive shake_hands_merge=0.
REQ-018 Throughput SHALL be one word per cycle under continuous ready; pop-to-output latency SHALL be 1 cycle; no channel waits more than NUM_CH-1 grants while non-empty.
REQ-019 OUT_W SHALL equal DATA_W, or CH_W+DATA_W with the macro of REQ-023.
REQ-020 route_data_proc SHALL be 0 whenever route_valid_proc=0.

Reset
REQ-021 While rst_n=0, the block SHALL hold state=IDLE, route_data_proc=0, route_valid_proc=0, shake_hands_merge=0 and ptr=NUM_CH-1, so channel 0 is granted first.
REQ-022 Reset asserted mid-transfer SHALL discard the held word; no pop SHALL be issued in the cycle rst_n deasserts unless load conditions hold after release.

Configuration
REQ-023 With DATA_ROUTE_CH_TAG_EN defined, route_data_proc SHALL be {granted channel index (CH_W bits), data}; without it, route_data_proc SHALL be data only and no tag logic SHALL exist.

Structure
REQ-024 Package data_route_pkg SHALL hold the FSM state enum (IDLE, FULL), the default DATA_W and the CH_W function.
REQ-025 The round-robin search (REQ-014) SHALL be sub-module rr_arb_sel: inputs req[NUM_CH] and ptr; outputs one-hot gnt, index and found.

Verification (NUM_CH=4, DATA_W=28)
REQ-026 Reset: rst_n=0 mid-stream -> all outputs 0 that cycle; after release, the first grant is channel 0.
REQ-027 All channels non-empty, ready=1 -> pops 0,1,2,3,0 on consecutive cycles; route_data_proc follows one cycle later.
REQ-028 Only channel 2 non-empty, ready=1 -> shake_hands_merge=4'b0100 every cycle; valid stays 1.
REQ-029 FULL with ready=0 for 5 cycles -> data stable, shake_hands_merge=0; ready=1 -> word consumed and the next channel popped the same cycle.
REQ-030 ptr=3, only channels 0 and 3 non-empty -> grant 0, then 3, then 0.
REQ-031 Macro on, channel 2 word 28'hABCDEF0 -> route_data_proc={2'd2,28'hABCDEF0}; macro off -> 28'hABCDEF0.

Source files
------------

// File: rtl/data_route_pkg.sv
// data_route_pkg: shared FSM state, default data width and channel-index width helper.
package data_route_pkg;
  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;
  localparam int DEF_DATA_W = 28;
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/data_route_arb_sel.sv
// rr_arb_sel: round-robin search starting after ptr, ascending with wrap.
module rr_arb_sel #(
  parameter int NUM_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              found
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_CH]) begin
        idx = CH_W'((int'(ptr) + k) % NUM_CH);
        found = 1'b1;
      end
    end
    gnt = found ? (NUM_CH'(1) << idx) : '0;
  end
endmodule

// File: rtl/data_route_arb.sv
// data_route_arb: round-robin merge of column-FIFO channels into one registered output.
// Define DATA_ROUTE_CH_TAG_EN to prefix each output word with its channel index.
module data_route_arb
  import data_route_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DEF_DATA_W,
  localparam int CH_W = ch_w(NUM_CH),
`ifdef DATA_ROUTE_CH_TAG_EN
  localparam int OUT_W = CH_W + DATA_W
`else
  localparam int OUT_W = DATA_W
`endif
) (
  input  logic                     clk_40MHz,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] route_data_in,
  input  logic [NUM_CH-1:0]        empty_merge,
  output logic [NUM_CH-1:0]        shake_hands_merge,
  input  logic                     shakehands_proc,
  output logic [OUT_W-1:0]         route_data_proc,
  output logic                     route_valid_proc
);
  state_t            state, state_nxt;
  logic [CH_W-1:0]   ptr, idx;
  logic [NUM_CH-1:0] gnt;
  logic              found, load;
  logic [DATA_W-1:0] word;

  assign load = (state == IDLE) | (shakehands_proc & route_valid_proc);
  assign word = route_data_in[idx*DATA_W +: DATA_W];

  rr_arb_sel #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_sel (
    .req(~empty_merge),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .found(found)
  );

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb state_nxt = load ? (found ? FULL : IDLE) : state;

  // Pops are gated by rst_n so nothing is popped while reset is held.
  always_comb begin
    shake_hands_merge = (rst_n && load) ? gnt : '0;
    route_valid_proc = (state == FULL);
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CH_W'(NUM_CH - 1);
      route_data_proc <= '0;
    end else if (load) begin
      if (found) begin
        ptr <= idx;
`ifdef DATA_ROUTE_CH_TAG_EN
        route_data_proc <= {idx, word};
`else
        route_data_proc <= word;
`endif
      end else begin
        route_data_proc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_route_arb.sv
// tb_data_route_arb: directed self-checking bench for data_route_arb (NUM_CH=4, DATA_W=28).
`timescale 1ns/1ps
module tb_data_route_arb;
`ifdef DATA_ROUTE_CH_TAG_EN
  localparam int OUT_W = 30;
`else
  localparam int OUT_W = 28;
`endif
  logic             clk_40MHz = 1'b0;
  logic             rst_n = 1'b0;
  logic [27:0]      words [4];
  logic [111:0]     route_data_in;
  logic [3:0]       empty_merge = 4'b1111;
  logic [3:0]       shake_hands_merge;
  logic             shakehands_proc = 1'b0;
  logic [OUT_W-1:0] route_data_proc;
  logic             route_valid_proc;
  int               total = 0;
  int               bad = 0;

  always #12.5 clk_40MHz = ~clk_40MHz;
  assign route_data_in = {words[3], words[2], words[1], words[0]};

  data_route_arb #(.NUM_CH(4), .DATA_W(28)) dut (
    .clk_40MHz(clk_40MHz),
    .rst_n(rst_n),
    .route_data_in(route_data_in),
    .empty_merge(empty_merge),
    .shake_hands_merge(shake_hands_merge),
    .shakehands_proc(shakehands_proc),
    .route_data_proc(route_data_proc),
    .route_valid_proc(route_valid_proc)
  );

  function automatic logic [OUT_W-1:0] exp_out(input int ch);
`ifdef DATA_ROUTE_CH_TAG_EN
    return {2'(ch), words[ch]};
`else
    return words[ch];
`endif
  endfunction

  task automatic tick();
    @(posedge clk_40MHz);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    empty_merge = 4'b0000;
    shakehands_proc = 1'b1;
    tick();
    tick();
    total++; if (shake_hands_merge !== 4'b0000) begin bad++; $display("FAIL rst_shake got=%b exp=0000", shake_hands_merge); end
    total++; if (route_valid_proc !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", route_valid_proc); end
    total++; if (route_data_proc !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", route_data_proc); end
    @(negedge clk_40MHz);
    rst_n = 1'b1;
    #1;
    total++; if (shake_hands_merge !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", shake_hands_merge); end
  endtask

  task automatic test_all_nonempty();
    for (int k = 0; k < 5; k++) begin
      total++; if (shake_hands_merge !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_pop%0d got=%b exp=%b", k, shake_hands_merge, 4'(1 << (k % 4))); end
      tick();
      total++; if (route_valid_proc !== 1'b1 || route_data_proc !== exp_out(k % 4)) begin bad++; $display("FAIL rr_data%0d got=%b/%h exp=1/%h", k, route_valid_proc, route_data_proc, exp_out(k % 4)); end
    end
  endtask

  task automatic test_single_ch();
    empty_merge = 4'b1011;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (shake_hands_merge !== 4'b0100) begin bad++; $display("FAIL single_pop%0d got=%b exp=0100", k, shake_hands_merge); end
      tick();
      total++; if (route_valid_proc !== 1'b1 || route_data_proc !== exp_out(2)) begin bad++; $display("FAIL single_data%0d got=%b/%h exp=1/%h", k, route_valid_proc, route_data_proc, exp_out(2)); end
    end
  endtask

  task automatic test_stall();
    empty_merge = 4'b0000;
    shakehands_proc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (shake_hands_merge !== 4'b0000) begin bad++; $display("FAIL stall_pop%0d got=%b exp=0000", k, shake_hands_merge); end
      tick();
      total++; if (route_valid_proc !== 1'b1 || route_data_proc !== exp_out(2)) begin bad++; $display("FAIL stall_data%0d got=%b/%h exp=1/%h", k, route_valid_proc, route_data_proc, exp_out(2)); end
    end
    shakehands_proc = 1'b1;
    #1;
    total++; if (shake_hands_merge !== 4'b1000) begin bad++; $display("FAIL stall_release got=%b exp=1000", shake_hands_merge); end
    tick();
    total++; if (route_data_proc !== exp_out(3)) begin bad++; $display("FAIL stall_next got=%h exp=%h", route_data_proc, exp_out(3)); end
  endtask

  task automatic test_wrap();
    int seq [3] = '{0, 3, 0};
    empty_merge = 4'b0110;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (shake_hands_merge !== 4'(1 << seq[k])) begin bad++; $display("FAIL wrap_pop%0d got=%b exp=%b", k, shake_hands_merge, 4'(1 << seq[k])); end
      tick();
      total++; if (route_data_proc !== exp_out(seq[k])) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", k, route_data_proc, exp_out(seq[k])); end
    end
  endtask

  task automatic test_empty_idle();
    empty_merge = 4'b1111;
    #1;
    total++; if (shake_hands_merge !== 4'b0000) begin bad++; $display("FAIL empty_pop got=%b exp=0000", shake_hands_merge); end
    tick();
    total++; if (route_valid_proc !== 1'b0 || route_data_proc !== '0) begin bad++; $display("FAIL empty_out got=%b/%h exp=0/0", route_valid_proc, route_data_proc); end
    empty_merge = 4'b0000;
    #1;
    total++; if (shake_hands_merge !== 4'b0010) begin bad++; $display("FAIL empty_ptr_kept got=%b exp=0010", shake_hands_merge); end
    tick();
    total++; if (route_valid_proc !== 1'b1 || route_data_proc !== exp_out(1)) begin bad++; $display("FAIL empty_resume got=%b/%h exp=1/%h", route_valid_proc, route_data_proc, exp_out(1)); end
  endtask

  task automatic test_tag();
    logic [OUT_W-1:0] exp;
`ifdef DATA_ROUTE_CH_TAG_EN
    exp = 30'h2ABCDEF0;
`else
    exp = 28'hABCDEF0;
`endif
    empty_merge = 4'b1011;
    #1;
    total++; if (shake_hands_merge !== 4'b0100) begin bad++; $display("FAIL tag_pop got=%b exp=0100", shake_hands_merge); end
    tick();
    total++; if (route_data_proc !== exp) begin bad++; $display("FAIL tag_data got=%h exp=%h", route_data_proc, exp); end
  endtask

  task automatic test_mid_reset();
    empty_merge = 4'b0000;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (shake_hands_merge !== 4'b0000 || route_valid_proc !== 1'b0 || route_data_proc !== '0) begin bad++; $display("FAIL midrst_out got=%b/%b/%h exp=0000/0/0", shake_hands_merge, route_valid_proc, route_data_proc); end
    empty_merge = 4'b1111;
    @(negedge clk_40MHz);
    rst_n = 1'b1;
    #1;
    total++; if (shake_hands_merge !== 4'b0000) begin bad++; $display("FAIL midrst_nopop got=%b exp=0000", shake_hands_merge); end
    empty_merge = 4'b1101;
    #1;
    total++; if (shake_hands_merge !== 4'b0010) begin bad++; $display("FAIL midrst_grant got=%b exp=0010", shake_hands_merge); end
    tick();
    total++; if (route_valid_proc !== 1'b1 || route_data_proc !== exp_out(1)) begin bad++; $display("FAIL midrst_data got=%b/%h exp=1/%h", route_valid_proc, route_data_proc, exp_out(1)); end
  endtask

  initial begin
    words[0] = 28'h1234567;
    words[1] = 28'h89ABCDE;
    words[2] = 28'hABCDEF0;
    words[3] = 28'h0F1E2D3;
    test_reset();
    test_all_nonempty();
    test_single_ch();
    test_stall();
    test_wrap();
    test_empty_idle();
    test_tag();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
